menu_nav_ctrl: RTL and testbench
================================

# menu_nav_ctrl

Parametrised front-panel navigation controller. It turns debounced key events into a two-level menu state: a top-level page cursor, a per-page field cursor, per-field value settings and a commit strobe. The block sits between the six `buttopn_debounde` instances and the consumers of menu state (`sig_gen`, `oscilloscope_top`, `hdmi_dis_top`). It generalises the hard-wired top-level FSM to N pages and N fields, and adds per-page value retention, saturate/wrap selection, key priority and hold-to-repeat.

## Interface
- `N_MENU`, 3: number of top-level pages, 2..8
- `N_FIELD`, 5: rows per page; rows 0..N_FIELD-2 are value fields, row N_FIELD-1 is the apply row
- `VAL_W`, 2: width of each field value
- `VAL_MAX`, 3: largest legal value, ≤ 2^VAL_W−1
- `WRAP`, 1: 1 = values wrap at 0/VAL_MAX; 0 = values saturate
- `REPEAT_DLY`, 25_000_000: hold cycles before the first auto-repeat (0.5 s)
- `REPEAT_PER`, 5_000_000: cycles between subsequent repeats (0.1 s)

Ports:
- `clk_50M`, in, 1: clock
- `rst_n`, in, 1: reset, synchronous, active-low
- `key_press`, in, 6: one-cycle release pulses, bit order {quit, confirm, down, up, right, left}
- `key_level`, in, 6: debounced key levels, same bit order, 1 = held
- `menu_sel`, out, MSEL_W = max(1, clog2(N_MENU)): top-level cursor
- `in_page`, out, 1: 1 = inside a page
- `field_sel`, out, FSEL_W = clog2(N_FIELD): row cursor
- `field_val`, out, (N_FIELD−1)·VAL_W: values of the current page; field i is at [i·VAL_W +: VAL_W]
- `commit`, out, 1: one-cycle pulse when confirm is applied on the apply row
- `committed`, out, 1: level; set by commit, cleared by quit or by any value edit

## Operation
- **Reset values:** all outputs 0, all value storage 0, repeat counter 0, state TOP.
- **State machine:** TOP ↔ PAGE. A single registered state register; there is no combinational next-state latch.
- **Event formation:** ev = key_press | rep_tick. The repeat tick applies to left/right/up/down only.
- **Priority:** at most one action per cycle. quit > confirm > up/down > left/right. Within a pair, up beats down and left beats right.
- **TOP state:**
  - left decrements `menu_sel` and right increments it, always wrapping over 0..N_MENU−1.
  - confirm → PAGE, with `in_page` = 1 and `field_sel` = 0. The page index equals `menu_sel`.
  - up, down and quit are ignored.
- **PAGE state:**
  - up decrements `field_sel` and down increments it, always wrapping over 0..N_FIELD−1.
  - left/right on a value row decrement/increment that row's value of page `menu_sel`. The value wraps or saturates per WRAP. An edit clears `committed`, even when a saturated value does not change.
  - left/right on the apply row are ignored.
  - confirm on the apply row pulses `commit` and sets `committed`. confirm on any other row is ignored.
  - quit → TOP, with `field_sel` = 0, `committed` = 0 and `menu_sel` unchanged.
- **Value retention:** each page keeps its own N_FIELD−1 values across exits. Only reset clears them.
- **Auto-repeat:**
  - The counter runs while exactly one of key_level[3:0] is high.
  - The first tick comes REPEAT_DLY cycles after that level rises; later ticks come every REPEAT_PER cycles.
  - The counter clears when no key is held, when two or more keys are held, or when the held key changes.

## Timing
- Every output is registered. An action taken on the cycle a `key_press` or tick is high becomes visible on the following edge (1-cycle latency).
- `commit` is high for exactly one cycle, aligned with `committed` rising.
- A reset asserted mid-operation, including during a repeat or in PAGE, returns everything to reset values on the next edge.
- Simultaneous quit + confirm in PAGE: quit wins and no commit is issued.
- Simultaneous confirm + right in TOP: the block enters PAGE and `menu_sel` does not move.

## Structure
- Package `menu_nav_pkg`:
  - state enum {TOP, PAGE};
  - key bit-index constants K_LEFT=0, K_RIGHT=1, K_UP=2, K_DOWN=3, K_CONFIRM=4, K_QUIT=5;
  - a width helper function.
- Sub-module `key_repeat`: the hold counter and tick generator, parametrised by REPEAT_DLY and REPEAT_PER. It takes `key_level`[3:0] and outputs a 4-bit `rep_tick`.
- Value storage is an N_MENU × (N_FIELD−1) × VAL_W register array. `field_val` is a registered mux of it by `menu_sel`.

## Test plan
- **Reset, then TOP wrap:** apply left, then right ×3 → `menu_sel` 0→2→0→1→2 with `in_page` held at 0.
- **Enter page 1 and edit row 1:** right, confirm, down, right ×2 → `field_sel`=1, `field_val`[3:2]=2. Then quit, then confirm again → value is still 2 and `field_sel`=0.
- **Saturate mode (WRAP=0, VAL_MAX=3):** right ×5 on row 0 → value stops at 3. With WRAP=1 → 1.
- **Commit:**
  - down ×4 to the apply row, then confirm → `commit` high for exactly 1 cycle and `committed`=1;
  - left on the apply row → no change;
  - up, then right → `committed`=0.
- **Auto-repeat (REPEAT_DLY=10, REPEAT_PER=4):** hold right for 22 cycles in TOP → ticks at cycles 10, 14, 18, 22 (N_MENU=8 so no wrap ambiguity). Holding up+right together → no ticks.
- **Priority and reset:**
  - quit + confirm in the same cycle on the apply row → TOP with no `commit`;
  - `rst_n`=0 for one cycle mid-repeat → all outputs and values return to 0.

Source files
------------

// File: rtl/menu_nav_pkg.sv
// Shared types and constants for the front-panel menu navigator.
package menu_nav_pkg;

  typedef enum logic {
    TOP  = 1'b0,
    PAGE = 1'b1
  } state_t;

  localparam int K_LEFT    = 0;
  localparam int K_RIGHT   = 1;
  localparam int K_UP      = 2;
  localparam int K_DOWN    = 3;
  localparam int K_CONFIRM = 4;
  localparam int K_QUIT    = 5;

  function automatic int w_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Hold-to-repeat tick generator for the four cursor keys.
import menu_nav_pkg::*;

module key_repeat #(
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [3:0] key_level,
  output logic [3:0] rep_tick
);

  localparam int MX = (REPEAT_DLY > REPEAT_PER) ?
                      REPEAT_DLY : REPEAT_PER;
  localparam int CW = w_of(MX + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic [3:0]    held;
  logic          rpt;
  logic          solo;
  logic          same;

  assign solo = $onehot(key_level);
  assign same = solo && (key_level == held);
  // first interval is the long delay, then the short period
  assign lim  = rpt ? CW'(REPEAT_PER) : CW'(REPEAT_DLY);

  assign rep_tick = (same && cnt == lim) ? held : 4'b0000;

  always_ff @(posedge clk_50M) begin
    if (!rst_n || !solo) begin
      cnt  <= '0;
      held <= '0;
      rpt  <= 1'b0;
    end else if (!same) begin
      held <= key_level;
      cnt  <= CW'(1);
      rpt  <= 1'b0;
    end else if (cnt == lim) begin
      cnt <= CW'(1);
      rpt <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/menu_nav_ctrl.sv
// Two-level menu navigator: page cursor, field cursor,
// per-page values, commit strobe and key auto-repeat.
import menu_nav_pkg::*;

module menu_nav_ctrl #(
  parameter int N_MENU     = 3,
  parameter int N_FIELD    = 5,
  parameter int VAL_W      = 2,
  parameter int VAL_MAX    = 3,
  parameter int WRAP       = 1,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic                           clk_50M,
  input  logic                           rst_n,
  input  logic [5:0]                     key_press,
  input  logic [5:0]                     key_level,
  output logic [w_of(N_MENU)-1:0]        menu_sel,
  output logic                           in_page,
  output logic [w_of(N_FIELD)-1:0]       field_sel,
  output logic [(N_FIELD-1)*VAL_W-1:0]   field_val,
  output logic                           commit,
  output logic                           committed
);

  localparam int MSEL_W = w_of(N_MENU);
  localparam int FSEL_W = w_of(N_FIELD);
  localparam int NV     = N_FIELD - 1;
  localparam int NPG    = 2 ** MSEL_W;

  typedef logic [NV-1:0][VAL_W-1:0] row_t;

  state_t            state, state_nxt;
  logic [MSEL_W-1:0] msel_nxt;
  logic [FSEL_W-1:0] fsel_nxt;
  logic              commit_nxt;
  logic              committed_nxt;
  row_t              vals [NPG];
  row_t              row_cur, row_nxt;
  logic [3:0]        rep_tick;
  logic [5:0]        ev, msk, act;
  logic              on_apply;
  logic              wr;
  logic [VAL_W-1:0]  cur_v, new_v;
  logic              unused_lvl;

  key_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_rep (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .key_level(key_level[3:0]),
    .rep_tick (rep_tick)
  );

  assign unused_lvl = ^key_level[5:4];
  assign ev         = key_press | {2'b00, rep_tick};
  assign on_apply   = (field_sel == FSEL_W'(NV));
  assign row_cur    = vals[menu_sel];
  assign in_page    = (state == PAGE);

  function automatic logic [VAL_W-1:0] step_v(
    input logic [VAL_W-1:0] v,
    input logic             inc
  );
    if (inc)
      return (v == VAL_W'(VAL_MAX)) ?
             ((WRAP != 0) ? '0 : v) : v + 1'b1;
    return (v == '0) ?
           ((WRAP != 0) ? VAL_W'(VAL_MAX) : v) : v - 1'b1;
  endfunction

  always_comb begin
    cur_v = '0;
    for (int i = 0; i < NV; i++)
      if (field_sel == FSEL_W'(i)) cur_v = row_cur[i];
  end

  // keys that are meaningless in the current state/row are masked
  // before priority so they never steal the cycle
  always_comb begin
    msk = '0;
    unique case (state)
      TOP: begin
        msk[K_CONFIRM] = ev[K_CONFIRM];
        msk[K_LEFT]    = ev[K_LEFT];
        msk[K_RIGHT]   = ev[K_RIGHT];
      end
      PAGE: begin
        msk[K_QUIT]    = ev[K_QUIT];
        msk[K_CONFIRM] = ev[K_CONFIRM] & on_apply;
        msk[K_UP]      = ev[K_UP];
        msk[K_DOWN]    = ev[K_DOWN];
        msk[K_LEFT]    = ev[K_LEFT] & ~on_apply;
        msk[K_RIGHT]   = ev[K_RIGHT] & ~on_apply;
      end
    endcase
    act = '0;
    if (msk[K_QUIT])         act[K_QUIT]    = 1'b1;
    else if (msk[K_CONFIRM]) act[K_CONFIRM] = 1'b1;
    else if (msk[K_UP])      act[K_UP]      = 1'b1;
    else if (msk[K_DOWN])    act[K_DOWN]    = 1'b1;
    else if (msk[K_LEFT])    act[K_LEFT]    = 1'b1;
    else if (msk[K_RIGHT])   act[K_RIGHT]   = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    msel_nxt      = menu_sel;
    fsel_nxt      = field_sel;
    commit_nxt    = 1'b0;
    committed_nxt = committed;
    wr            = 1'b0;
    new_v         = cur_v;
    unique case (1'b1)
      act[K_QUIT]: begin
        state_nxt     = TOP;
        fsel_nxt      = '0;
        committed_nxt = 1'b0;
      end
      act[K_CONFIRM]: begin
        if (state == TOP) begin
          state_nxt = PAGE;
          fsel_nxt  = '0;
        end else begin
          commit_nxt    = 1'b1;
          committed_nxt = 1'b1;
        end
      end
      act[K_UP]:
        fsel_nxt = (field_sel == '0) ?
                   FSEL_W'(N_FIELD - 1) : field_sel - 1'b1;
      act[K_DOWN]:
        fsel_nxt = (field_sel == FSEL_W'(N_FIELD - 1)) ?
                   '0 : field_sel + 1'b1;
      act[K_LEFT], act[K_RIGHT]: begin
        if (state == TOP) begin
          if (act[K_LEFT])
            msel_nxt = (menu_sel == '0) ?
                       MSEL_W'(N_MENU - 1) : menu_sel - 1'b1;
          else
            msel_nxt = (menu_sel == MSEL_W'(N_MENU - 1)) ?
                       '0 : menu_sel + 1'b1;
        end else begin
          wr            = 1'b1;
          new_v         = step_v(cur_v, act[K_RIGHT]);
          committed_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // edits never move menu_sel, so the edited row is the next view
  always_comb begin
    row_nxt = vals[msel_nxt];
    for (int i = 0; i < NV; i++)
      if (wr && field_sel == FSEL_W'(i)) row_nxt[i] = new_v;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state     <= TOP;
      menu_sel  <= '0;
      field_sel <= '0;
      field_val <= '0;
      commit    <= 1'b0;
      committed <= 1'b0;
      for (int m = 0; m < NPG; m++) vals[m] <= '0;
    end else begin
      state     <= state_nxt;
      menu_sel  <= msel_nxt;
      field_sel <= fsel_nxt;
      field_val <= row_nxt;
      commit    <= commit_nxt;
      committed <= committed_nxt;
      if (wr) vals[menu_sel] <= row_nxt;
    end
  end

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Scoreboard bench: two configurations driven in lockstep,
// each checked every cycle against a behavioural menu model.
module tb_menu_nav_ctrl;

  localparam int DLY = 10;
  localparam int PER = 4;
  localparam int NF  = 5;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic [5:0] key_press = '0;
  logic [5:0] key_level = '0;

  logic [1:0] msel0;
  logic [2:0] msel1;
  logic       inp0, inp1, cm0, cm1, cmd0, cmd1;
  logic [2:0] fsel0, fsel1;
  logic [7:0] fval0, fval1;

  always #10 clk_50M = ~clk_50M;

  menu_nav_ctrl #(
    .N_MENU(3), .N_FIELD(NF), .VAL_W(2), .VAL_MAX(3), .WRAP(1),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut0 (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .key_press(key_press), .key_level(key_level),
    .menu_sel(msel0), .in_page(inp0), .field_sel(fsel0),
    .field_val(fval0), .commit(cm0), .committed(cmd0)
  );

  menu_nav_ctrl #(
    .N_MENU(8), .N_FIELD(NF), .VAL_W(2), .VAL_MAX(2), .WRAP(0),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut1 (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .key_press(key_press), .key_level(key_level),
    .menu_sel(msel1), .in_page(inp1), .field_sel(fsel1),
    .field_val(fval1), .commit(cm1), .committed(cmd1)
  );

  typedef struct {
    int msel; int inp; int fsel; int fval; int cm; int cmd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  int nm  [2] = '{3, 8};
  int vmx [2] = '{3, 2};
  int wrp [2] = '{1, 0};
  int m_menu [2];
  int m_field[2];
  int m_inp  [2];
  int m_cmd  [2];
  int m_cm   [2];
  int m_vals [2][8][4];
  int rp_key = -1;
  int rp_len = 0;

  task automatic cmp(input int k, input string n,
                     input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0d required=%0d t=%0t",
               k, n, a, e, $time);
    end
  endtask

  task automatic chk(input int k, input exp_t e, input exp_t a);
    cmp(k, "menu_sel",  a.msel, e.msel);
    cmp(k, "in_page",   a.inp,  e.inp);
    cmp(k, "field_sel", a.fsel, e.fsel);
    cmp(k, "field_val", a.fval, e.fval);
    cmp(k, "commit",    a.cm,   e.cm);
    cmp(k, "committed", a.cmd,  e.cmd);
  endtask

  task automatic model_step(input logic [5:0] p,
                            input logic [5:0] l,
                            input logic r);
    logic [3:0] tick;
    logic [5:0] ev;
    int         hk;
    int         ap;
    exp_t       e;
    tick = '0;
    hk = -1;
    if ($countones(l[3:0]) == 1)
      for (int i = 0; i < 4; i++) if (l[i]) hk = i;
    if (!r || hk < 0) begin
      rp_key = -1;
      rp_len = 0;
    end else begin
      if (hk == rp_key) rp_len++;
      else begin
        rp_key = hk;
        rp_len = 0;
      end
      if (rp_len >= DLY && ((rp_len - DLY) % PER) == 0)
        tick[hk] = 1'b1;
    end
    ev = p | {2'b00, tick};
    for (int k = 0; k < 2; k++) begin
      m_cm[k] = 0;
      if (!r) begin
        m_menu[k] = 0; m_field[k] = 0; m_inp[k] = 0; m_cmd[k] = 0;
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 4; b++) m_vals[k][a][b] = 0;
      end else if (m_inp[k] == 0) begin
        if (ev[4]) begin
          m_inp[k] = 1; m_field[k] = 0;
        end else if (ev[0]) m_menu[k] = (m_menu[k] + nm[k] - 1) % nm[k];
        else if (ev[1]) m_menu[k] = (m_menu[k] + 1) % nm[k];
      end else begin
        ap = (m_field[k] == NF - 1);
        if (ev[5]) begin
          m_inp[k] = 0; m_field[k] = 0; m_cmd[k] = 0;
        end else if (ev[4] && ap) begin
          m_cm[k] = 1; m_cmd[k] = 1;
        end else if (ev[2]) m_field[k] = (m_field[k] + NF - 1) % NF;
        else if (ev[3]) m_field[k] = (m_field[k] + 1) % NF;
        else if ((ev[0] || ev[1]) && !ap) begin
          int v;
          v = m_vals[k][m_menu[k]][m_field[k]];
          if (ev[0]) v = (v == 0) ? (wrp[k] ? vmx[k] : 0) : v - 1;
          else       v = (v == vmx[k]) ? (wrp[k] ? 0 : v) : v + 1;
          m_vals[k][m_menu[k]][m_field[k]] = v;
          m_cmd[k] = 0;
        end
      end
      e.msel = m_menu[k]; e.inp = m_inp[k]; e.fsel = m_field[k];
      e.cm = m_cm[k]; e.cmd = m_cmd[k];
      e.fval = 0;
      for (int i = 0; i < 4; i++)
        e.fval += m_vals[k][m_menu[k]][i] << (2 * i);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic step(input logic [5:0] p, input logic [5:0] l,
                      input logic r);
    @(negedge clk_50M);
    key_press = p;
    key_level = l;
    rst_n     = r;
    model_step(p, l, r);
  endtask

  task automatic hold(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) step(6'd0, l, 1'b1);
  endtask

  always @(posedge clk_50M) begin
    exp_t a;
    #1;
    if (q0.size() > 0) begin
      a.msel = int'(msel0); a.inp = int'(inp0); a.fsel = int'(fsel0);
      a.fval = int'(fval0); a.cm = int'(cm0); a.cmd = int'(cmd0);
      chk(0, q0.pop_front(), a);
    end
    if (q1.size() > 0) begin
      a.msel = int'(msel1); a.inp = int'(inp1); a.fsel = int'(fsel1);
      a.fval = int'(fval1); a.cm = int'(cm1); a.cmd = int'(cmd1);
      chk(1, q1.pop_front(), a);
    end
  end

  localparam logic [5:0] L = 6'd1,  R = 6'd2,  U = 6'd4;
  localparam logic [5:0] D = 6'd8,  C = 6'd16, Q = 6'd32;

  logic [5:0] seq [] = '{
    L, R, R, R, R, C, D, R, R, Q, C,
    U, D, Q, C, R, R, R, R, R,
    D, D, D, D, C, L, U, R, D, C,
    Q | C, C, Q, R, C | R, D, D, D, D, Q | C, Q
  };

  initial begin
    logic [5:0] lvl;
    logic [5:0] p;
    int         r2;
    step(6'd0, 6'd0, 1'b0);
    step(6'd0, 6'd0, 1'b0);
    foreach (seq[i]) step(seq[i], 6'd0, 1'b1);
    hold(R, 23);
    hold(6'd0, 2);
    hold(U | R, 20);
    hold(6'd0, 1);
    step(C, 6'd0, 1'b1);
    hold(R, 12);
    step(6'd0, R, 1'b0);
    hold(R, 16);
    hold(6'd0, 2);
    lvl = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        r2 = $urandom_range(0, 5);
        if (r2 < 2)      lvl = '0;
        else if (r2 < 5) lvl = 6'd1 << $urandom_range(0, 3);
        else             lvl = 6'($urandom) & 6'h0f;
      end
      p  = '0;
      r2 = $urandom_range(0, 99);
      if (r2 < 25)      p[$urandom_range(0, 5)] = 1'b1;
      else if (r2 < 30) p = 6'($urandom);
      step(p, lvl, $urandom_range(0, 499) != 0);
    end
    hold(6'd0, 2);
    @(posedge clk_50M);
    #2;
    cmp(0, "queue_drain", q0.size(), 0);
    cmp(1, "queue_drain", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
